// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
//   Groups the instruction-memory request/response channel and the decode
//   hand-off channel of the fetch stage.
//   master : fetch sequencer side (drives requests, presents instructions)
//   slave  : memory/decode side
// Signals
//   imem_req_valid / imem_req_ready / imem_req_addr : read request handshake
//   imem_rsp_valid / imem_rsp_data                  : in-order read response
//   inst_valid / inst_ready / inst_data / inst_pc   : instruction to decode
interface fetch_sequencer_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst_data;
  logic [XLEN-1:0] inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Drives the program counter and a single-outstanding instruction-memory
//   request for the fetch stage, hands fetched words to decode, and applies
//   branch/jump redirects through the PC load path, discarding stale fetches.
// Ports
//   clk             clock, posedge
//   reset_n         synchronous active-low reset
//   pc_enable_n     0 = program counter steps/loads this edge (forced 0 in reset)
//   pc_reset_n      program counter reset, follows reset_n
//   pc_load         program counter loads pc_new_address instead of stepping
//   pc_new_address  redirect destination, word aligned
//   pc_address      current PC, meaningful only while pc_enable_n = 0
//   halt            stop starting new fetches
//   redirect_valid  one-cycle taken branch/jump pulse
//   redirect_target redirect destination
//   bus             imem request/response and decode channels (master side)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | PC released; waiting for halt to drop
// STEP  | sample PC into fetch_addr while PC advances by 4
// REQ   | imem request presented, held until accepted
// WAIT  | request accepted, waiting for the response
// OUT   | instruction presented to decode
// LOAD  | PC loaded with the redirect target
module fetch_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            pc_enable_n,
  output logic            pc_reset_n,
  output logic            pc_load,
  output logic [XLEN-1:0] pc_new_address,
  input  logic [XLEN-1:0] pc_address,
  input  logic            halt,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  fetch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_LOAD
  } state_t;

  state_t          state;
  logic            pending;
  logic            discard;
  logic [XLEN-1:0] pend_target;
  logic [XLEN-1:0] fetch_addr;
  logic            redirect_seen;
  logic [XLEN-1:0] load_target;

  // A redirect either already captured or arriving this cycle.
  assign redirect_seen = pending | redirect_valid;

  assign pc_reset_n = reset_n;

  // During reset the PC must be enabled so it sees its own reset.
  assign pc_enable_n = reset_n & ~((state == S_STEP) | (state == S_LOAD));

  // A redirect arriving in LOAD itself is used directly rather than captured.
  assign load_target    = redirect_valid ? redirect_target : pend_target;
  assign pc_new_address = {load_target[XLEN-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state              <= S_IDLE;
      pending            <= 1'b0;
      discard            <= 1'b0;
      pend_target        <= '0;
      fetch_addr         <= '0;
      pc_load            <= 1'b0;
      bus.imem_req_valid <= 1'b0;
      bus.imem_req_addr  <= '0;
      bus.inst_valid     <= 1'b0;
      bus.inst_data      <= '0;
      bus.inst_pc        <= '0;
    end else begin
      // Last redirect wins; LOAD consumes redirects directly.
      if (redirect_valid && (state != S_LOAD)) begin
        pending     <= 1'b1;
        pend_target <= redirect_target;
      end

      pc_load <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!halt) begin
            if (pending) begin
              state   <= S_LOAD;
              pc_load <= 1'b1;
            end else begin
              state <= S_STEP;
            end
          end
        end

        S_STEP: begin
          fetch_addr <= pc_address;
          if (redirect_seen) begin
            state   <= S_LOAD;
            pc_load <= 1'b1;
          end else begin
            state              <= S_REQ;
            bus.imem_req_valid <= 1'b1;
            bus.imem_req_addr  <= pc_address;
          end
        end

        S_REQ: begin
          // Never withdrawn: a redirect only marks the response as stale.
          if (bus.imem_req_ready) begin
            bus.imem_req_valid <= 1'b0;
            discard            <= redirect_seen;
            state              <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            if (discard || redirect_seen) begin
              discard <= 1'b0;
              state   <= S_LOAD;
              pc_load <= 1'b1;
            end else begin
              bus.inst_data  <= bus.imem_rsp_data;
              bus.inst_pc    <= fetch_addr;
              bus.inst_valid <= 1'b1;
              state          <= S_OUT;
            end
          end
        end

        S_OUT: begin
          // Redirect squashes the instruction even if decode takes it now.
          if (redirect_seen) begin
            bus.inst_valid <= 1'b0;
            state          <= S_LOAD;
            pc_load        <= 1'b1;
          end else if (bus.inst_ready) begin
            bus.inst_valid <= 1'b0;
            state          <= halt ? S_IDLE : S_STEP;
          end
        end

        S_LOAD: begin
          pending <= 1'b0;
          state   <= halt ? S_IDLE : S_STEP;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Directed bench for fetch_sequencer with a program counter model
//   (reset value 0x80000000, +4 step, load) and a 1-cycle in-order memory
//   returning the bitwise inverse of the request address.
module tb_fetch_sequencer;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            pc_enable_n;
  logic            pc_reset_n;
  logic            pc_load;
  logic [XLEN-1:0] pc_new_address;
  logic [XLEN-1:0] pc_address = '0;
  logic            halt;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;

  fetch_sequencer_if #(.XLEN(XLEN)) bus ();

  fetch_sequencer #(.XLEN(XLEN)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pc_enable_n     (pc_enable_n),
    .pc_reset_n      (pc_reset_n),
    .pc_load         (pc_load),
    .pc_new_address  (pc_new_address),
    .pc_address      (pc_address),
    .halt            (halt),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  // program counter model
  always @(posedge clk) begin
    if (!pc_enable_n) begin
      if (!pc_reset_n)   pc_address <= 32'h8000_0000;
      else if (pc_load)  pc_address <= pc_new_address;
      else               pc_address <= pc_address + 32'd4;
    end
  end

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] req_log[$];
  logic [31:0] pc_log[$];
  logic [31:0] data_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Records handshakes completing at the coming posedge, advances to the
  // next negedge and presents the memory response one cycle after acceptance.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = (bus.imem_req_valid === 1'b1) && (bus.imem_req_ready === 1'b1);
    a   = bus.imem_req_addr;
    if (acc) req_log.push_back(a);
    if ((bus.inst_valid === 1'b1) && (bus.inst_ready === 1'b1)) begin
      pc_log.push_back(bus.inst_pc);
      data_log.push_back(bus.inst_data);
    end
    @(negedge clk);
    bus.imem_rsp_valid = acc;
    bus.imem_rsp_data  = acc ? ~a : 32'h0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    req_log.delete();
    pc_log.delete();
    data_log.delete();
  endtask

  initial begin
    reset_n            = 1'b0;
    halt               = 1'b1;
    redirect_valid     = 1'b0;
    redirect_target    = '0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.inst_ready     = 1'b1;

    // reset values
    ticks(2);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_pc_load", 32'(pc_load), 32'd0);
    chk("rst_req_addr", bus.imem_req_addr, 32'h0);
    chk("rst_inst_data", bus.inst_data, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
    chk("rst_pc_enable_n", 32'(pc_enable_n), 32'd0);
    chk("rst_pc_reset_n", 32'(pc_reset_n), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("idle_pc_enable_n", 32'(pc_enable_n), 32'd1);

    // 1: sequential fetch, 4 cycles per instruction
    clear_logs();
    halt = 1'b0;
    ticks(12);
    halt = 1'b1;
    tick();
    chk("t1_req_cnt", 32'(req_log.size()), 32'd3);
    chk("t1_req0", req_log[0], 32'h8000_0000);
    chk("t1_req1", req_log[1], 32'h8000_0004);
    chk("t1_req2", req_log[2], 32'h8000_0008);
    chk("t1_inst_cnt", 32'(pc_log.size()), 32'd3);
    chk("t1_pc0", pc_log[0], 32'h8000_0000);
    chk("t1_pc1", pc_log[1], 32'h8000_0004);
    chk("t1_pc2", pc_log[2], 32'h8000_0008);
    chk("t1_data0", data_log[0], 32'h7FFF_FFFF);
    chk("t1_data2", data_log[2], 32'h7FFF_FFF7);

    // 2: decode back-pressure in OUT
    clear_logs();
    halt = 1'b0;
    bus.inst_ready = 1'b0;
    ticks(4);
    chk("t2_out_valid", 32'(bus.inst_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", 32'(bus.inst_valid), 32'd1);
      chk("t2_hold_pc", bus.inst_pc, 32'h8000_000C);
      chk("t2_hold_data", bus.inst_data, 32'h7FFF_FFF3);
      chk("t2_no_req", 32'(bus.imem_req_valid), 32'd0);
    end
    chk("t2_req_cnt", 32'(req_log.size()), 32'd1);
    bus.inst_ready = 1'b1;
    halt = 1'b1;
    tick();
    chk("t2_inst_cnt", 32'(pc_log.size()), 32'd1);
    chk("t2_pc", pc_log[0], 32'h8000_000C);

    // 6: reset in WAIT, then refetch from the reset PC
    halt = 1'b0;
    ticks(3);
    reset_n = 1'b0;
    tick();
    chk("t6_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("t6_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("t6_pc_load", 32'(pc_load), 32'd0);
    chk("t6_req_addr", bus.imem_req_addr, 32'h0);
    chk("t6_inst_data", bus.inst_data, 32'h0);
    chk("t6_inst_pc", bus.inst_pc, 32'h0);
    chk("t6_pc_enable_n", 32'(pc_enable_n), 32'd0);
    reset_n = 1'b1;

    // 3: redirect during WAIT of 0x80000004
    clear_logs();
    ticks(7);
    redirect_valid  = 1'b1;
    redirect_target = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    chk("t3_pc_load", 32'(pc_load), 32'd1);
    chk("t3_pc_enable_n", 32'(pc_enable_n), 32'd0);
    chk("t3_new_addr", pc_new_address, 32'h8000_0100);
    ticks(4);
    halt = 1'b1;
    tick();
    chk("t3_req_cnt", 32'(req_log.size()), 32'd3);
    chk("t6_refetch", req_log[0], 32'h8000_0000);
    chk("t3_req1", req_log[1], 32'h8000_0004);
    chk("t3_req2", req_log[2], 32'h8000_0100);
    chk("t3_inst_cnt", 32'(pc_log.size()), 32'd2);
    chk("t3_pc0", pc_log[0], 32'h8000_0000);
    chk("t3_pc1", pc_log[1], 32'h8000_0100);
    chk("t3_data1", data_log[1], 32'h7FFF_FEFF);

    // 4: two redirects while the request is stalled; last one wins
    clear_logs();
    halt = 1'b0;
    bus.imem_req_ready = 1'b0;
    ticks(2);
    chk("t4_req_addr", bus.imem_req_addr, 32'h8000_0104);
    redirect_valid  = 1'b1;
    redirect_target = 32'h8000_0200;
    tick();
    redirect_target = 32'h8000_0300;
    tick();
    chk("t4_req_held", 32'(bus.imem_req_valid), 32'd1);
    redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    ticks(2);
    chk("t4_pc_load", 32'(pc_load), 32'd1);
    chk("t4_new_addr", pc_new_address, 32'h8000_0300);
    ticks(4);
    halt = 1'b1;
    tick();
    chk("t4_req_cnt", 32'(req_log.size()), 32'd2);
    chk("t4_req1", req_log[1], 32'h8000_0300);
    chk("t4_inst_cnt", 32'(pc_log.size()), 32'd1);
    chk("t4_pc0", pc_log[0], 32'h8000_0300);
    chk("t4_data0", data_log[0], 32'h7FFF_FCFF);

    // 5: memory not ready for 3 cycles
    clear_logs();
    halt = 1'b0;
    bus.imem_req_ready = 1'b0;
    ticks(2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_valid", 32'(bus.imem_req_valid), 32'd1);
      chk("t5_addr", bus.imem_req_addr, 32'h8000_0304);
    end
    bus.imem_req_ready = 1'b1;
    tick();
    chk("t5_valid_drop", 32'(bus.imem_req_valid), 32'd0);
    tick();
    halt = 1'b1;
    tick();
    chk("t5_req_cnt", 32'(req_log.size()), 32'd1);
    chk("t5_req0", req_log[0], 32'h8000_0304);
    chk("t5_pc0", pc_log[0], 32'h8000_0304);

    // redirect beats inst_ready in OUT; target bits [1:0] cleared
    clear_logs();
    halt = 1'b0;
    bus.inst_ready = 1'b0;
    ticks(4);
    chk("sq_out_valid", 32'(bus.inst_valid), 32'd1);
    bus.inst_ready  = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h8000_0402;
    tick();
    redirect_valid = 1'b0;
    chk("sq_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("sq_pc_load", 32'(pc_load), 32'd1);
    chk("sq_new_addr", pc_new_address, 32'h8000_0400);
    pc_log.delete();
    ticks(4);
    halt = 1'b1;
    tick();
    chk("sq_req_cnt", 32'(req_log.size()), 32'd2);
    chk("sq_req1", req_log[1], 32'h8000_0400);
    chk("sq_inst_cnt", 32'(pc_log.size()), 32'd1);
    chk("sq_pc0", pc_log[0], 32'h8000_0400);

    ticks(2);
    chk("end_pc_enable_n", 32'(pc_enable_n), 32'd1);
    chk("end_req_valid", 32'(bus.imem_req_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
